// File: rtl/bp_clint_responder.sv
// Single-hart CLINT responder: msip/mtimecmp/mtime registers, one command in flight.
// Response valid the cycle after accept and held until yumi; ready stays low while a response is pending.
module bp_clint_responder #(
  parameter int paddr_width_p = 56,
  parameter int data_width_p  = 64
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     mem_cmd_v_i,
  output logic                     mem_cmd_ready_o,
  input  logic                     mem_cmd_we_i,
  input  logic [paddr_width_p-1:0] mem_cmd_addr_i,
  input  logic [1:0]               mem_cmd_size_i,
  input  logic [data_width_p-1:0]  mem_cmd_data_i,
  output logic                     mem_resp_v_o,
  input  logic                     mem_resp_yumi_i,
  output logic [data_width_p-1:0]  mem_resp_data_o,
  output logic                     mem_resp_err_o,
  input  logic                     rtc_tick_i,
  output logic                     software_irq_o,
  output logic                     timer_irq_o
);

  typedef enum logic {IDLE, RESP} state_e;

  localparam logic [20:0] msip_word_lp     = 21'h000000;
  localparam logic [20:0] mtimecmp_word_lp = 21'h000800;
  localparam logic [20:0] mtime_word_lp    = 21'h0017FF;

  state_e                    state_q;
  logic                      ready_q;
  logic                      resp_v_q;
  logic                      resp_err_q;
  logic [data_width_p-1:0]   resp_data_q;
  logic [63:0]               mtime_q;
  logic [63:0]               mtimecmp_q;
  logic                      msip_q;
  logic                      sw_irq_q;
  logic                      timer_irq_q;

  logic                      accept;
  logic                      dev_hit;
  logic [23:0]               offset;
  logic                      hi_word;
  logic                      sel_msip;
  logic                      sel_cmp;
  logic                      sel_mtime;
  logic                      size_ok;
  logic                      err;
  logic [63:0]               reg_val;
  logic [data_width_p-1:0]   rdata;
  logic                      wr_msip;
  logic                      wr_cmp;
  logic                      wr_mtime;
  logic [63:0]               mtime_wval;
  logic [63:0]               mtimecmp_wval;

  // ready_q is only ever high in IDLE, so accept needs no state qualifier
  assign accept = mem_cmd_v_i & ready_q;

  always_comb begin
    dev_hit   = (mem_cmd_addr_i[paddr_width_p-1:24] == (paddr_width_p-24)'(2));
    offset    = mem_cmd_addr_i[23:0];
    hi_word   = offset[2];
    sel_msip  = dev_hit && (offset[23:3] == msip_word_lp);
    sel_cmp   = dev_hit && (offset[23:3] == mtimecmp_word_lp);
    sel_mtime = dev_hit && (offset[23:3] == mtime_word_lp);
    // msip only exists in the low word, so its upper 4B half is not a register
    size_ok   = ((mem_cmd_size_i == 2'd3) && (offset[2:0] == 3'b000))
             || ((mem_cmd_size_i == 2'd2) && (offset[1:0] == 2'b00) && !(sel_msip && hi_word));
    err       = !(size_ok && (sel_msip || sel_cmp || sel_mtime));

    reg_val = 64'h0;
    if (sel_msip)       reg_val = {63'h0, msip_q};
    else if (sel_cmp)   reg_val = mtimecmp_q;
    else if (sel_mtime) reg_val = mtime_q;

    rdata = '0;
    if (!err && !mem_cmd_we_i) begin
      if (mem_cmd_size_i == 2'd3) rdata = reg_val;
      else                        rdata = {32'h0, hi_word ? reg_val[63:32] : reg_val[31:0]};
    end

    wr_msip  = accept && mem_cmd_we_i && !err && sel_msip;
    wr_cmp   = accept && mem_cmd_we_i && !err && sel_cmp;
    wr_mtime = accept && mem_cmd_we_i && !err && sel_mtime;

    // 4B stores replace only the addressed half; the other half is untouched
    if (mem_cmd_size_i == 2'd3) begin
      mtime_wval    = mem_cmd_data_i;
      mtimecmp_wval = mem_cmd_data_i;
    end else if (hi_word) begin
      mtime_wval    = {mem_cmd_data_i[31:0], mtime_q[31:0]};
      mtimecmp_wval = {mem_cmd_data_i[31:0], mtimecmp_q[31:0]};
    end else begin
      mtime_wval    = {mtime_q[63:32], mem_cmd_data_i[31:0]};
      mtimecmp_wval = {mtimecmp_q[63:32], mem_cmd_data_i[31:0]};
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      resp_v_q    <= 1'b0;
      resp_err_q  <= 1'b0;
      resp_data_q <= '0;
      mtime_q     <= 64'h0;
      mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip_q      <= 1'b0;
      sw_irq_q    <= 1'b0;
      timer_irq_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q     <= RESP;
            ready_q     <= 1'b0;
            resp_v_q    <= 1'b1;
            resp_data_q <= rdata;
            resp_err_q  <= err;
          end else begin
            ready_q <= 1'b1;
          end
        end
        RESP: begin
          if (mem_resp_yumi_i) begin
            state_q     <= IDLE;
            ready_q     <= 1'b1;
            resp_v_q    <= 1'b0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
        end
      endcase

      // a store to mtime takes priority over a coincident tick
      if (wr_mtime)        mtime_q <= mtime_wval;
      else if (rtc_tick_i) mtime_q <= mtime_q + 64'd1;

      if (wr_cmp)  mtimecmp_q <= mtimecmp_wval;
      if (wr_msip) msip_q     <= mem_cmd_data_i[0];

      timer_irq_q <= (mtime_q >= mtimecmp_q);
      sw_irq_q    <= msip_q;
    end
  end

  assign mem_cmd_ready_o = ready_q;
  assign mem_resp_v_o    = resp_v_q;
  assign mem_resp_data_o = resp_data_q;
  assign mem_resp_err_o  = resp_err_q;
  assign software_irq_o  = sw_irq_q;
  assign timer_irq_o     = timer_irq_q;

endmodule

// File: tb/tb_bp_clint_responder.sv
// Directed bench for bp_clint_responder: vector table for decode/data, hand sequences for timing corners.
module tb_bp_clint_responder;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        mem_cmd_v_i;
  logic        mem_cmd_ready_o;
  logic        mem_cmd_we_i;
  logic [55:0] mem_cmd_addr_i;
  logic [1:0]  mem_cmd_size_i;
  logic [63:0] mem_cmd_data_i;
  logic        mem_resp_v_o;
  logic        mem_resp_yumi_i;
  logic [63:0] mem_resp_data_o;
  logic        mem_resp_err_o;
  logic        rtc_tick_i;
  logic        software_irq_o;
  logic        timer_irq_o;

  int passed = 0;
  int total  = 0;

  bp_clint_responder #(.paddr_width_p(56), .data_width_p(64)) dut (
    .clk_i          (clk_i),
    .reset_n_i      (reset_n_i),
    .mem_cmd_v_i    (mem_cmd_v_i),
    .mem_cmd_ready_o(mem_cmd_ready_o),
    .mem_cmd_we_i   (mem_cmd_we_i),
    .mem_cmd_addr_i (mem_cmd_addr_i),
    .mem_cmd_size_i (mem_cmd_size_i),
    .mem_cmd_data_i (mem_cmd_data_i),
    .mem_resp_v_o   (mem_resp_v_o),
    .mem_resp_yumi_i(mem_resp_yumi_i),
    .mem_resp_data_o(mem_resp_data_o),
    .mem_resp_err_o (mem_resp_err_o),
    .rtc_tick_i     (rtc_tick_i),
    .software_irq_o (software_irq_o),
    .timer_irq_o    (timer_irq_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        we;
    logic [55:0] addr;
    logic [1:0]  size;
    logic [63:0] wdata;
    logic [63:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs [25];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Full handshake; leaves the bench at a negedge with the DUT idle again.
  task automatic do_cmd(input logic we, input logic [55:0] addr, input logic [1:0] size,
                        input logic [63:0] wdata, input logic tk,
                        output logic [63:0] rd, output logic er);
    int n;
    @(negedge clk_i);
    mem_cmd_v_i    = 1'b1;
    mem_cmd_we_i   = we;
    mem_cmd_addr_i = addr;
    mem_cmd_size_i = size;
    mem_cmd_data_i = wdata;
    n = 0;
    while (!mem_cmd_ready_o && n < 50) begin @(negedge clk_i); n++; end
    if (n >= 50) chk("cmd_ready_timeout", 64'd0, 64'd1);
    rtc_tick_i = tk;
    @(posedge clk_i);
    @(negedge clk_i);
    mem_cmd_v_i = 1'b0;
    rtc_tick_i  = 1'b0;
    n = 0;
    while (!mem_resp_v_o && n < 50) begin @(negedge clk_i); n++; end
    if (n >= 50) chk("resp_v_timeout", 64'd0, 64'd1);
    rd = mem_resp_data_o;
    er = mem_resp_err_o;
    mem_resp_yumi_i = 1'b1;
    @(negedge clk_i);
    mem_resp_yumi_i = 1'b0;
  endtask

  logic [63:0] rd;
  logic        er;

  initial begin
    vecs[0]  = '{1'b0, 56'h0200BFF8, 2'd3, 64'h0, 64'h0, 1'b0};
    vecs[1]  = '{1'b0, 56'h02004000, 2'd3, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[2]  = '{1'b0, 56'h02004004, 2'd2, 64'h0, 64'h0000_0000_FFFF_FFFF, 1'b0};
    vecs[3]  = '{1'b1, 56'h02004000, 2'd3, 64'h1122_3344_5566_7788, 64'h0, 1'b0};
    vecs[4]  = '{1'b0, 56'h02004000, 2'd2, 64'h0, 64'h5566_7788, 1'b0};
    vecs[5]  = '{1'b0, 56'h02004004, 2'd2, 64'h0, 64'h1122_3344, 1'b0};
    vecs[6]  = '{1'b1, 56'h02004004, 2'd2, 64'hDEAD_BEEF_CAFE_F00D, 64'h0, 1'b0};
    vecs[7]  = '{1'b0, 56'h02004000, 2'd3, 64'h0, 64'hCAFE_F00D_5566_7788, 1'b0};
    vecs[8]  = '{1'b0, 56'h02004000, 2'd1, 64'h0, 64'h0, 1'b1};
    vecs[9]  = '{1'b0, 56'h02004004, 2'd3, 64'h0, 64'h0, 1'b1};
    vecs[10] = '{1'b0, 56'h03000000, 2'd3, 64'h0, 64'h0, 1'b1};
    vecs[11] = '{1'b1, 56'h02004004, 2'd3, 64'h0, 64'h0, 1'b1};
    vecs[12] = '{1'b1, 56'h02004001, 2'd2, 64'h0, 64'h0, 1'b1};
    vecs[13] = '{1'b1, 56'h02004000, 2'd0, 64'h0, 64'h0, 1'b1};
    vecs[14] = '{1'b0, 56'h02000004, 2'd2, 64'h0, 64'h0, 1'b1};
    vecs[15] = '{1'b0, 56'h0001_0200_4000, 2'd3, 64'h0, 64'h0, 1'b1};
    vecs[16] = '{1'b0, 56'h02001000, 2'd3, 64'h0, 64'h0, 1'b1};
    vecs[17] = '{1'b0, 56'h02004000, 2'd3, 64'h0, 64'hCAFE_F00D_5566_7788, 1'b0};
    vecs[18] = '{1'b1, 56'h0200BFF8, 2'd3, 64'h0000_0001_FFFF_FFFF, 64'h0, 1'b0};
    vecs[19] = '{1'b1, 56'h0200BFF8, 2'd2, 64'h5, 64'h0, 1'b0};
    vecs[20] = '{1'b0, 56'h0200BFF8, 2'd3, 64'h0, 64'h0000_0001_0000_0005, 1'b0};
    vecs[21] = '{1'b1, 56'h0200BFFC, 2'd2, 64'hA, 64'h0, 1'b0};
    vecs[22] = '{1'b0, 56'h0200BFF8, 2'd3, 64'h0, 64'h0000_000A_0000_0005, 1'b0};
    vecs[23] = '{1'b0, 56'h0200BFFC, 2'd2, 64'h0, 64'hA, 1'b0};
    vecs[24] = '{1'b0, 56'h02000000, 2'd3, 64'h0, 64'h0, 1'b0};

    reset_n_i = 1'b0; mem_cmd_v_i = 1'b0; mem_cmd_we_i = 1'b0; mem_cmd_addr_i = '0;
    mem_cmd_size_i = 2'd0; mem_cmd_data_i = '0; mem_resp_yumi_i = 1'b0; rtc_tick_i = 1'b0;

    // Reset state
    repeat (3) @(negedge clk_i);
    chk("rst_ready", {63'h0, mem_cmd_ready_o}, 64'd0);
    chk("rst_resp_v", {63'h0, mem_resp_v_o}, 64'd0);
    reset_n_i = 1'b1;
    @(negedge clk_i);
    chk("post_rst_ready", {63'h0, mem_cmd_ready_o}, 64'd1);
    chk("post_rst_resp_v", {63'h0, mem_resp_v_o}, 64'd0);
    chk("post_rst_timer_irq", {63'h0, timer_irq_o}, 64'd0);
    chk("post_rst_sw_irq", {63'h0, software_irq_o}, 64'd0);

    // Decode, data and error table
    for (int i = 0; i < 25; i++) begin
      do_cmd(vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].wdata, 1'b0, rd, er);
      chk($sformatf("vec%0d_data", i), rd, vecs[i].exp_data);
      chk($sformatf("vec%0d_err", i), {63'h0, er}, {63'h0, vecs[i].exp_err});
    end

    // msip store: response next cycle, interrupt one cycle after that
    @(negedge clk_i);
    mem_cmd_v_i = 1'b1; mem_cmd_we_i = 1'b1; mem_cmd_addr_i = 56'h02000000;
    mem_cmd_size_i = 2'd2; mem_cmd_data_i = 64'h1;
    @(posedge clk_i);
    @(negedge clk_i);
    mem_cmd_v_i = 1'b0;
    chk("msip_resp_latency", {63'h0, mem_resp_v_o}, 64'd1);
    chk("msip_irq_not_yet", {63'h0, software_irq_o}, 64'd0);
    mem_resp_yumi_i = 1'b1;
    @(negedge clk_i);
    mem_resp_yumi_i = 1'b0;
    chk("msip_irq_set", {63'h0, software_irq_o}, 64'd1);
    do_cmd(1'b0, 56'h02000000, 2'd2, 64'h0, 1'b0, rd, er);
    chk("msip_read1", rd, 64'h1);
    do_cmd(1'b1, 56'h02000000, 2'd2, 64'hFFFF_FFFE, 1'b0, rd, er);
    @(negedge clk_i);
    chk("msip_irq_clr", {63'h0, software_irq_o}, 64'd0);
    do_cmd(1'b0, 56'h02000000, 2'd3, 64'h0, 1'b0, rd, er);
    chk("msip_read0", rd, 64'h0);

    // Timer compare
    do_cmd(1'b1, 56'h0200BFF8, 2'd3, 64'h0, 1'b0, rd, er);
    do_cmd(1'b1, 56'h02004000, 2'd3, 64'd5, 1'b0, rd, er);
    @(negedge clk_i);
    chk("timer_irq_before", {63'h0, timer_irq_o}, 64'd0);
    for (int k = 0; k < 5; k++) begin
      rtc_tick_i = 1'b1;
      @(negedge clk_i);
      rtc_tick_i = 1'b0;
    end
    chk("timer_irq_same_cycle", {63'h0, timer_irq_o}, 64'd0);
    @(negedge clk_i);
    chk("timer_irq_rise", {63'h0, timer_irq_o}, 64'd1);
    do_cmd(1'b1, 56'h02004000, 2'd3, 64'd100, 1'b0, rd, er);
    chk("timer_irq_fall", {63'h0, timer_irq_o}, 64'd0);

    // mtime wrap and store/tick collision
    do_cmd(1'b1, 56'h0200BFF8, 2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, rd, er);
    rtc_tick_i = 1'b1;
    @(negedge clk_i);
    rtc_tick_i = 1'b0;
    do_cmd(1'b0, 56'h0200BFF8, 2'd3, 64'h0, 1'b0, rd, er);
    chk("mtime_wrap", rd, 64'h0);
    do_cmd(1'b1, 56'h0200BFF8, 2'd3, 64'd7, 1'b1, rd, er);
    do_cmd(1'b0, 56'h0200BFF8, 2'd3, 64'h0, 1'b0, rd, er);
    chk("mtime_store_wins", rd, 64'd7);

    // Backpressure: response held, second command blocked until after yumi
    @(negedge clk_i);
    mem_cmd_v_i = 1'b1; mem_cmd_we_i = 1'b0; mem_cmd_addr_i = 56'h02004000;
    mem_cmd_size_i = 2'd3; mem_cmd_data_i = 64'h0;
    @(posedge clk_i);
    @(negedge clk_i);
    mem_cmd_v_i = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c == 2) begin
        mem_cmd_v_i = 1'b1; mem_cmd_we_i = 1'b1; mem_cmd_data_i = 64'd200;
      end
      chk($sformatf("bp_v_%0d", c), {63'h0, mem_resp_v_o}, 64'd1);
      chk($sformatf("bp_data_%0d", c), mem_resp_data_o, 64'd100);
      chk($sformatf("bp_ready_%0d", c), {63'h0, mem_cmd_ready_o}, 64'd0);
      @(negedge clk_i);
    end
    mem_resp_yumi_i = 1'b1;
    @(negedge clk_i);
    mem_resp_yumi_i = 1'b0;
    chk("bp_after_yumi_ready", {63'h0, mem_cmd_ready_o}, 64'd1);
    chk("bp_after_yumi_resp_v", {63'h0, mem_resp_v_o}, 64'd0);
    @(posedge clk_i);
    @(negedge clk_i);
    mem_cmd_v_i = 1'b0;
    chk("bp_second_accepted", {63'h0, mem_resp_v_o}, 64'd1);
    chk("bp_second_ready", {63'h0, mem_cmd_ready_o}, 64'd0);
    mem_resp_yumi_i = 1'b1;
    @(negedge clk_i);
    mem_resp_yumi_i = 1'b0;
    do_cmd(1'b0, 56'h02004000, 2'd3, 64'h0, 1'b0, rd, er);
    chk("bp_second_store", rd, 64'd200);

    // Reset in the middle of a transaction
    do_cmd(1'b1, 56'h02000000, 2'd3, 64'h1, 1'b0, rd, er);
    @(negedge clk_i);
    mem_cmd_v_i = 1'b1; mem_cmd_we_i = 1'b0; mem_cmd_addr_i = 56'h02004000; mem_cmd_size_i = 2'd3;
    @(posedge clk_i);
    @(negedge clk_i);
    mem_cmd_v_i = 1'b0;
    chk("midrst_pending", {63'h0, mem_resp_v_o}, 64'd1);
    reset_n_i = 1'b0;
    #1;
    chk("midrst_resp_v", {63'h0, mem_resp_v_o}, 64'd0);
    chk("midrst_sw_irq", {63'h0, software_irq_o}, 64'd0);
    chk("midrst_ready", {63'h0, mem_cmd_ready_o}, 64'd0);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    do_cmd(1'b0, 56'h02004000, 2'd3, 64'h0, 1'b0, rd, er);
    chk("midrst_mtimecmp", rd, 64'hFFFF_FFFF_FFFF_FFFF);
    do_cmd(1'b0, 56'h02000000, 2'd2, 64'h0, 1'b0, rd, er);
    chk("midrst_msip", rd, 64'h0);
    do_cmd(1'b0, 56'h0200BFF8, 2'd3, 64'h0, 1'b0, rd, er);
    chk("midrst_mtime", rd, 64'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
